// File: rtl/seq_mag_comparator.sv
// Slice-serial magnitude comparator (unsigned or two's-complement), MSB slice first with early exit.
// Latency: 1..NSLICE cycles from the start edge to the done pulse (first differing slice, or NSLICE).
// No backpressure: start is ignored while busy, abort cancels silently, done is a one-cycle pulse.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic [2:0]       cascade_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       result
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sm_q, sm_d;
    logic [2:0]       casc_q, casc_d;
    logic             done_q, done_d;
    logic [2:0]       result_q, result_d;

    logic [WIDTH-1:0] a_eff, b_eff;
    logic [SLICE-1:0] slice_a, slice_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order;
    // it only touches the top slice, so lower slices stay unsigned.
    assign a_eff = a_q ^ {sm_q, {(WIDTH-1){1'b0}}};
    assign b_eff = b_q ^ {sm_q, {(WIDTH-1){1'b0}}};

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                slice_a = a_eff[i*SLICE +: SLICE];
                slice_b = b_eff[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sm_d     = sm_q;
        casc_d   = casc_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    casc_d  = cascade_in;
                    idx_d   = IW'(NSLICE - 1);
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (slice_a > slice_b) begin
                    result_d = RES_GT;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (slice_a < slice_b) begin
                    result_d = RES_LT;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (idx_q == '0) begin
                    // All slices equal: defer to the lower-order stage; invalid codes read as equal.
                    if (casc_q == RES_GT)      result_d = RES_GT;
                    else if (casc_q == RES_LT) result_d = RES_LT;
                    else                       result_d = RES_EQ;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sm_q     <= 1'b0;
            casc_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sm_q     <= sm_d;
            casc_q   <= casc_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == COMPARE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator (WIDTH=16, SLICE=4): vector table plus hand-written
// sequences for back-to-back, ignored start, abort and asynchronous reset.
module tb_seq_mag_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_mode;
    logic [2:0]  cascade_in;
    logic        busy;
    logic        done;
    logic [2:0]  result;

    int tests = 0;
    int fails = 0;

    seq_mag_comparator #(.WIDTH(16), .SLICE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .cascade_in  (cascade_in),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] va;
        logic [15:0] vb;
        logic        sm;
        logic [2:0]  casc;
        logic [2:0]  res;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Called at #1 after a rising edge; returns latency in cycles (99 = no done within budget).
    task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb, input logic tsm,
                           input logic [2:0] tc, output int lat, output logic [2:0] res,
                           output bit held);
        logic [2:0] prev;
        a = ta; b = tb; signed_mode = tsm; cascade_in = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb; signed_mode = ~tsm; cascade_in = ~tc;
        prev = result;
        held = 1'b1;
        lat  = 99;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
            if (result != prev) held = 1'b0;
        end
        res = result;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [2:0] res;
        bit         held;
        bit         saw_done;

        vecs[0]  = '{"u_8000_7fff",  16'h8000, 16'h7FFF, 1'b0, 3'b001, 3'b100, 1};
        vecs[1]  = '{"s_8000_7fff",  16'h8000, 16'h7FFF, 1'b1, 3'b001, 3'b010, 1};
        vecs[2]  = '{"eq_casc_lt",   16'h1234, 16'h1234, 1'b0, 3'b010, 3'b010, 4};
        vecs[3]  = '{"eq_casc_000",  16'h1234, 16'h1234, 1'b0, 3'b000, 3'b001, 4};
        vecs[4]  = '{"lsb_gt",       16'h1235, 16'h1234, 1'b0, 3'b000, 3'b100, 4};
        vecs[5]  = '{"b2b_msb_lt",   16'h0000, 16'hF000, 1'b0, 3'b100, 3'b010, 1};
        vecs[6]  = '{"s_m1_vs_1",    16'hFFFF, 16'h0001, 1'b1, 3'b001, 3'b010, 1};
        vecs[7]  = '{"slice2_lt",    16'h1200, 16'h1300, 1'b0, 3'b100, 3'b010, 2};
        vecs[8]  = '{"slice1_lt",    16'h1234, 16'h1244, 1'b0, 3'b100, 3'b010, 3};
        vecs[9]  = '{"eq_casc_gt",   16'hABCD, 16'hABCD, 1'b0, 3'b100, 3'b100, 4};
        vecs[10] = '{"eq_multihot",  16'h5555, 16'h5555, 1'b0, 3'b011, 3'b001, 4};
        vecs[11] = '{"s_low_gt",     16'hFFF1, 16'hFFF0, 1'b1, 3'b010, 3'b100, 4};
        vecs[12] = '{"s_neg_pos",    16'hC000, 16'h4000, 1'b1, 3'b100, 3'b010, 1};
        vecs[13] = '{"s_casc_ign",   16'h7FFF, 16'h8000, 1'b1, 3'b010, 3'b100, 1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0; cascade_in = '0;
        #3;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Each vector starts on the cycle right after the previous done: back-to-back throughout.
        for (int i = 0; i < 14; i++) begin
            run_cmp(vecs[i].va, vecs[i].vb, vecs[i].sm, vecs[i].casc, lat, res, held);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_result"}, res, vecs[i].res);
            check({vecs[i].name, "_result_held"}, held, 1);
        end
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);

        // Start during a 4-slice compare must be ignored.
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; cascade_in = 3'b100; start = 1'b1;
        @(posedge clk); #1;
        check("busy_after_start", busy, 1);
        a = 16'h0000; b = 16'hFFFF; cascade_in = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 99;
        for (int c = 2; c <= 10; c++) begin
            if (done) begin
                lat = c - 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("ignored_start_latency", lat, 4);
        check("ignored_start_result", result, 3'b100);

        // Abort on the second compare cycle: no done, result keeps 100.
        a = 16'h1111; b = 16'h1111; cascade_in = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_late_done", saw_done, 0);
        check("abort_result_held", result, 3'b100);

        // Abort with start in IDLE wins.
        a = 16'h0001; b = 16'h0000; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", busy, 0);

        // Asynchronous reset between edges mid-compare; start already waiting at release.
        a = 16'h2222; b = 16'h2222; cascade_in = 3'b100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_done", done, 0);
        check("mid_reset_result", result, 0);
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("reset_no_done", saw_done, 0);
        a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; start = 1'b1;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_reset_accept", busy, 1);
        check("post_reset_no_done", done, 0);
        @(posedge clk); #1;
        check("post_reset_done", done, 1);
        check("post_reset_result", result, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
